// File: rtl/rx_ltssm_sequencer.sv
// Receive-side LTSSM substate sequencer: counts consecutive ordered sets per substate,
// advances from Detect.Quiet to Configuration.Idle. Optional macro RX_SEQ_TIMEOUT_EN adds ms timeouts.
module rx_ltssm_sequencer #(
  parameter int DEVICETYPE        = 0,
  parameter int POLL_ACTIVE_CNT   = 8,
  parameter int POLL_CFG_CNT      = 8,
  parameter int CFG_CNT           = 2,
  parameter int TO_POLL_ACTIVE_MS = 24,
  parameter int TO_POLL_CFG_MS    = 48,
  parameter int TO_CFG_MS         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ms_tick,
  input  logic       countup,
  input  logic       resetcounter,
  input  logic [7:0] rateid_in,
  output logic [3:0] substate,
  output logic       checker_rst_n,
  output logic [4:0] os_count,
  output logic [7:0] link_rateid,
  output logic       state_done,
  output logic       timeout,
  output logic       linkup
);

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIGURATION = 4'd3,
    CFG_LW_START          = 4'd4,
    CFG_LW_ACCEPT         = 4'd5,
    CFG_LN_WAIT           = 4'd6,
    CFG_LN_ACCEPT         = 4'd7,
    CFG_COMPLETE          = 4'd8,
    CFG_IDLE              = 4'd9
  } state_t;

  state_t     state_r, state_nx_s;
  logic [4:0] os_count_r, os_count_nx_s;
  logic [7:0] link_rateid_r, link_rateid_nx_s;
  logic       state_done_r, state_done_nx_s;
  logic       timeout_r, timeout_nx_s;
  logic       linkup_r, linkup_nx_s;
  logic       checker_rst_n_r, checker_rst_n_nx_s;
  logic       counting_s, thr_hit_s, to_hit_s, abort_s;
  logic [31:0] unused_cfg_s;

  function automatic logic [4:0] threshold_of(input state_t s);
    case (s)
      POLLING_ACTIVE:        threshold_of = 5'(POLL_ACTIVE_CNT);
      POLLING_CONFIGURATION: threshold_of = 5'(POLL_CFG_CNT);
      default:               threshold_of = 5'(CFG_CNT);
    endcase
  endfunction

  assign counting_s = (state_r >= POLLING_ACTIVE) && (state_r <= CFG_COMPLETE);
  assign thr_hit_s  = counting_s && (os_count_r == threshold_of(state_r));
  assign abort_s    = !start && (state_r != DETECT_QUIET);

`ifdef RX_SEQ_TIMEOUT_EN
  logic [7:0] timer_r, timer_nx_s;

  function automatic logic [7:0] limit_of(input state_t s);
    case (s)
      POLLING_ACTIVE:        limit_of = 8'(TO_POLL_ACTIVE_MS);
      POLLING_CONFIGURATION: limit_of = 8'(TO_POLL_CFG_MS);
      default:               limit_of = 8'(TO_CFG_MS);
    endcase
  endfunction

  assign to_hit_s     = counting_s && (timer_r == limit_of(state_r));
  assign unused_cfg_s = 32'(DEVICETYPE);

  // ms timer: cleared on any substate change, counts ticks only while counting
  always_comb begin
    timer_nx_s = timer_r;
    if (abort_s || thr_hit_s || to_hit_s || !counting_s) begin
      timer_nx_s = 8'd0;
    end else if (ms_tick) begin
      timer_nx_s = timer_r + 8'd1;
    end else begin
      timer_nx_s = timer_r;
    end
  end

  // ms timer register
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 8'd0;
    end else begin
      timer_r <= timer_nx_s;
    end
  end
`else
  assign to_hit_s     = 1'b0;
  assign unused_cfg_s = {31'd0, ms_tick} ^ 32'(DEVICETYPE) ^ 32'(TO_POLL_ACTIVE_MS)
                      ^ 32'(TO_POLL_CFG_MS) ^ 32'(TO_CFG_MS);
`endif

  // Next substate and outputs; link drop beats advance, advance beats timeout
  always_comb begin
    state_nx_s         = state_r;
    os_count_nx_s      = os_count_r;
    link_rateid_nx_s   = link_rateid_r;
    state_done_nx_s    = 1'b0;
    timeout_nx_s       = 1'b0;
    checker_rst_n_nx_s = 1'b1;
    if (abort_s) begin
      state_nx_s         = DETECT_QUIET;
      os_count_nx_s      = 5'd0;
      checker_rst_n_nx_s = 1'b0;
    end else if (thr_hit_s) begin
      state_nx_s         = state_t'(state_r + 4'd1);
      os_count_nx_s      = 5'd0;
      state_done_nx_s    = 1'b1;
      checker_rst_n_nx_s = 1'b0;
      if (state_r == POLLING_CONFIGURATION) begin
        link_rateid_nx_s = rateid_in;
      end else begin
        link_rateid_nx_s = link_rateid_r;
      end
    end else if (to_hit_s) begin
      state_nx_s         = DETECT_QUIET;
      os_count_nx_s      = 5'd0;
      timeout_nx_s       = 1'b1;
      checker_rst_n_nx_s = 1'b0;
    end else begin
      case (state_r)
        DETECT_QUIET: begin
          if (start) begin
            state_nx_s = DETECT_ACTIVE;
          end else begin
            state_nx_s = DETECT_QUIET;
          end
        end
        DETECT_ACTIVE: state_nx_s = POLLING_ACTIVE;
        CFG_IDLE:      state_nx_s = CFG_IDLE;
        default: begin
          // Checker reports are meaningless while it is being flushed
          if (!counting_s) begin
            state_nx_s    = DETECT_QUIET;
            os_count_nx_s = 5'd0;
          end else if (!checker_rst_n_r) begin
            os_count_nx_s = os_count_r;
          end else if (resetcounter) begin
            os_count_nx_s = 5'd0;
          end else if (countup && (os_count_r != 5'd31)) begin
            os_count_nx_s = os_count_r + 5'd1;
          end else begin
            os_count_nx_s = os_count_r;
          end
        end
      endcase
    end
    linkup_nx_s = (state_nx_s == CFG_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= DETECT_QUIET;
      os_count_r      <= 5'd0;
      link_rateid_r   <= 8'd0;
      state_done_r    <= 1'b0;
      timeout_r       <= 1'b0;
      linkup_r        <= 1'b0;
      checker_rst_n_r <= 1'b0;
    end else begin
      state_r         <= state_nx_s;
      os_count_r      <= os_count_nx_s;
      link_rateid_r   <= link_rateid_nx_s;
      state_done_r    <= state_done_nx_s;
      timeout_r       <= timeout_nx_s;
      linkup_r        <= linkup_nx_s;
      checker_rst_n_r <= checker_rst_n_nx_s;
    end
  end

  assign substate      = state_r;
  assign os_count      = os_count_r;
  assign link_rateid   = link_rateid_r;
  assign state_done    = state_done_r;
  assign timeout       = timeout_r;
  assign linkup        = linkup_r;
  assign checker_rst_n = checker_rst_n_r;

endmodule

// File: tb/tb_rx_ltssm_sequencer.sv
// Scoreboard bench for rx_ltssm_sequencer: directed test-plan sequences plus randomized traffic,
// each cycle predicted by a behavioural model; follows RX_SEQ_TIMEOUT_EN like the design.
module tb_rx_ltssm_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ms_tick = 1'b0;
  logic       countup = 1'b0;
  logic       resetcounter = 1'b0;
  logic [7:0] rateid_in = 8'd0;
  logic [3:0] substate;
  logic       checker_rst_n;
  logic [4:0] os_count;
  logic [7:0] link_rateid;
  logic       state_done;
  logic       timeout;
  logic       linkup;

`ifdef RX_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  rx_ltssm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ms_tick(ms_tick),
    .countup(countup), .resetcounter(resetcounter), .rateid_in(rateid_in),
    .substate(substate), .checker_rst_n(checker_rst_n), .os_count(os_count),
    .link_rateid(link_rateid), .state_done(state_done), .timeout(timeout),
    .linkup(linkup)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ss;
    logic       crn;
    logic [4:0] cnt;
    logic [7:0] rate;
    logic       done;
    logic       to;
    logic       lu;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] cur_rid = 8'h00;

  // Reference model state: substate number, consecutive count, elapsed ms, outputs
  int m_ss = 0, m_cnt = 0, m_tmr = 0;
  logic [7:0] m_rate = 8'd0;
  logic m_crn = 1'b0, m_done = 1'b0, m_to = 1'b0;

  function automatic int needed_sets(int s);
    if (s == 2) return 8;
    if (s == 3) return 8;
    return 2;
  endfunction

  function automatic int allowed_ms(int s);
    if (s == 3) return 48;
    return 24;
  endfunction

  task automatic model_step(input logic r, st, tk, cu, rc, input logic [7:0] rid);
    logic was_live;
    bit   counting_state;
    exp_t e;
    if (r) begin
      m_ss = 0; m_cnt = 0; m_tmr = 0; m_rate = 8'd0;
      m_crn = 1'b0; m_done = 1'b0; m_to = 1'b0;
    end else begin
      was_live = m_crn;
      counting_state = (m_ss >= 2) && (m_ss <= 8);
      m_crn = 1'b1; m_done = 1'b0; m_to = 1'b0;
      if (!st && m_ss != 0) begin
        m_ss = 0; m_cnt = 0; m_tmr = 0; m_crn = 1'b0;
      end else if (counting_state && m_cnt == needed_sets(m_ss)) begin
        if (m_ss == 3) m_rate = rid;
        m_ss = m_ss + 1; m_cnt = 0; m_tmr = 0; m_crn = 1'b0; m_done = 1'b1;
      end else if (TO_EN && counting_state && m_tmr == allowed_ms(m_ss)) begin
        m_ss = 0; m_cnt = 0; m_tmr = 0; m_crn = 1'b0; m_to = 1'b1;
      end else if (m_ss == 0) begin
        if (st) m_ss = 1;
      end else if (m_ss == 1) begin
        m_ss = 2;
      end else if (counting_state) begin
        if (was_live) begin
          if (rc) m_cnt = 0;
          else if (cu) m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
        end
        if (TO_EN && tk) m_tmr = m_tmr + 1;
      end
    end
    e.ss = 4'(m_ss); e.crn = m_crn; e.cnt = 5'(m_cnt); e.rate = m_rate;
    e.done = m_done; e.to = m_to; e.lu = (m_ss == 9);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, st, tk, cu, rc);
    reset = r; start = st; ms_tick = tk; countup = cu; resetcounter = rc; rateid_in = cur_rid;
    model_step(r, st, tk, cu, rc, cur_rid);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sets(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Advance edge, flush cycle, then n matching sets
  task automatic adv_state(input int n);
    idle(2);
    sets(n);
  endtask

  function automatic bit fld(string name, logic [7:0] got, logic [7:0] want);
    if (got !== want) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: every cycle the design presents a new output set, compare with the oldest prediction
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bad = 1'b0;
        bad |= fld("substate", {4'd0, substate}, {4'd0, e.ss});
        bad |= fld("checker_rst_n", {7'd0, checker_rst_n}, {7'd0, e.crn});
        bad |= fld("os_count", {3'd0, os_count}, {3'd0, e.cnt});
        bad |= fld("link_rateid", link_rateid, e.rate);
        bad |= fld("state_done", {7'd0, state_done}, {7'd0, e.done});
        bad |= fld("timeout", {7'd0, timeout}, {7'd0, e.to});
        bad |= fld("linkup", {7'd0, linkup}, {7'd0, e.lu});
        vectors++;
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    int mode;
    #2;
    // Reset, then straight through Polling.Active
    do_reset();
    idle(1);
    adv_state(8);
    idle(3);
    // resetcounter mid-run, then countup together with resetcounter
    do_reset();
    idle(1);
    adv_state(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    sets(8);
    // Polling.Configuration captures the rate, then walk to Configuration.Idle
    cur_rid = 8'h1E;
    adv_state(8);
    for (int s = 4; s <= 8; s++) adv_state(2);
    idle(3);
    cur_rid = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Polling.Active with 24 ms and no sets
    do_reset();
    idle(2);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Threshold reached on the same cycle as the 24th ms in CfgLWAccept
    do_reset();
    idle(1);
    adv_state(8);
    adv_state(8);
    adv_state(2);
    idle(1);
    for (int i = 0; i < 23; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Randomized traffic: alternate progress-heavy and timeout-heavy phases
    for (int i = 0; i < 4000; i++) begin
      logic r, st, tk, cu, rc;
      mode = (i / 250) % 2;
      cur_rid = 8'($urandom);
      r  = ($urandom_range(0, 999) < 2);
      st = ($urandom_range(0, 999) >= 4);
      if (mode == 0) begin
        cu = ($urandom_range(0, 99) < 75);
        rc = ($urandom_range(0, 99) < 3);
        tk = ($urandom_range(0, 99) < 5);
      end else begin
        cu = ($urandom_range(0, 99) < 25);
        rc = ($urandom_range(0, 99) < 20);
        tk = ($urandom_range(0, 99) < 60);
      end
      drive(r, st, tk, cu, rc);
    end
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
